// File: rtl/ysyx_23060077_pipe_adder.sv
// Pipelined add/sub/SLT/SLTU unit: each stage adds one WIDTH/STAGES chunk and ripples the carry onward.
// Latency STAGES cycles, one op per cycle; a stage holds when its successor is full and not draining.
// Backpressure from out_ready reaches in_ready combinationally. YSYX_23060077_ADDER_SAT_EN adds in_sat (saturating ADD/SUB).
module ysyx_23060077_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
`ifdef YSYX_23060077_ADDER_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    logic [STAGES-1:0] vld, adv, ld;
    logic              in_fire;
    logic              sat_in;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic [1:0]       op_q  [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
    logic             sat_q [STAGES];

    logic [WIDTH-1:0] res_q;
    logic             carry_q, ovf_q, zero_q;

`ifdef YSYX_23060077_ADDER_SAT_EN
    assign sat_in = in_sat;
`else
    assign sat_in = 1'b0;
`endif

    // Walk from the output back: a stage is free if empty or draining this cycle.
    always_comb begin
        logic free;
        adv  = '0;
        ld   = '0;
        free = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = vld[k] && free;
            free   = !vld[k] || adv[k];
        end
        in_ready = !reset && !flush && free;
        in_fire  = in_valid && in_ready;
        ld[0]    = in_fire;
        for (int k = 1; k < STAGES; k++) begin
            ld[k] = adv[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld[k] <= 1'b1;
                end else if (adv[k]) begin
                    vld[k] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] p_a, p_b, p_s, s_n;
        logic             p_c, p_sat;
        logic [1:0]       p_op;
        logic [TAG_W-1:0] p_tag;
        logic [CHUNK:0]   csum;

        if (k == 0) begin : g_src
            // Subtract and compares share the adder as a + ~b + 1.
            assign p_a   = in_a;
            assign p_b   = (in_op == OP_ADD) ? in_b : ~in_b;
            assign p_s   = '0;
            assign p_c   = (in_op != OP_ADD);
            assign p_op  = in_op;
            assign p_tag = in_tag;
            assign p_sat = sat_in;
        end else begin : g_src
            assign p_a   = a_q[k-1];
            assign p_b   = b_q[k-1];
            assign p_s   = s_q[k-1];
            assign p_c   = c_q[k-1];
            assign p_op  = op_q[k-1];
            assign p_tag = tag_q[k-1];
            assign p_sat = sat_q[k-1];
        end

        assign csum = {1'b0, p_a[k*CHUNK +: CHUNK]} + {1'b0, p_b[k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, p_c};

        always_comb begin
            s_n = p_s;
            s_n[k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                op_q[k]  <= '0;
                tag_q[k] <= '0;
                sat_q[k] <= 1'b0;
            end else if (ld[k]) begin
                a_q[k]   <= p_a;
                b_q[k]   <= p_b;
                s_q[k]   <= s_n;
                c_q[k]   <= csum[CHUNK];
                op_q[k]  <= p_op;
                tag_q[k] <= p_tag;
                sat_q[k] <= p_sat;
            end
        end

        if (k == STAGES - 1) begin : g_fin
            logic             ovf;
            logic [WIDTH-1:0] res;

            assign ovf = (p_a[WIDTH-1] == p_b[WIDTH-1]) & (p_a[WIDTH-1] ^ s_n[WIDTH-1]);

            always_comb begin
                res = s_n;
                case (p_op)
                    OP_SLT:  res = {{(WIDTH-1){1'b0}}, s_n[WIDTH-1] ^ ovf};
                    OP_SLTU: res = {{(WIDTH-1){1'b0}}, ~csum[CHUNK]};
                    default: begin
                        // Overflow direction follows the sign of a (operands share a sign).
                        if (p_sat && ovf) begin
                            res = p_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                        end
                    end
                endcase
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    res_q   <= '0;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    zero_q  <= 1'b0;
                end else if (ld[k]) begin
                    res_q   <= res;
                    carry_q <= csum[CHUNK];
                    ovf_q   <= ovf;
                    zero_q  <= (res == '0);
                end
            end
        end
    end

    assign out_valid  = vld[STAGES-1];
    assign out_result = res_q;
    assign out_carry  = carry_q;
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;
    assign out_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_ysyx_23060077_pipe_adder.sv
// Scoreboard bench for ysyx_23060077_pipe_adder (WIDTH=32, STAGES=4); directed vectors with hand-computed results.
module tb_ysyx_23060077_pipe_adder;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, SLT = 2'b10, SLTU = 2'b11;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic        out_carry, out_ovf, out_zero;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag;
`ifdef YSYX_23060077_ADDER_SAT_EN
    logic        in_sat;
`endif

    ysyx_23060077_pipe_adder #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
`ifdef YSYX_23060077_ADDER_SAT_EN
        .in_sat(in_sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [3:0]  tag;
        logic        sat;
        logic [31:0] res;
        logic        c, v, z;
    } vec_t;

    typedef struct {
        logic [38:0] resp;
        int          issue;
        bit          chk_lat;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, n_acc = 0;
    bit   lat_mode = 1'b0, last_rdy = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic sat, input logic [31:0] res,
                        input logic c, input logic v, input logic z);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.tag = tag; t.sat = sat;
        t.res = res; t.c = c; t.v = v; t.z = z;
        vq.push_back(t);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    initial begin : mon
        logic [38:0] got, held;
        bit          stalled;
        exp_t        e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clock); #1;
            got = {out_result, out_carry, out_ovf, out_zero, out_tag};
            if (reset !== 1'b0) begin
                stalled = 1'b0;
            end else if (out_valid === 1'b1) begin
                if (stalled) check("stall_hold", 64'(got), 64'(held));
                if (out_ready) begin
                    stalled = 1'b0;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out: got %h expected no output", got);
                    end else begin
                        e = sb.pop_front();
                        check("result", 64'(got), 64'(e.resp));
                        if (e.chk_lat) check("latency", 64'(cyc - e.issue), 64'd4);
                    end
                end else begin
                    stalled = 1'b1;
                    held    = got;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic step(input bit offer, input bit ordy);
        bit acc;
        int iss;
        @(negedge clock);
        out_ready = ordy;
        if (offer && vq.size() > 0) begin
            in_valid = 1'b1;
            in_op    = vq[0].op;
            in_a     = vq[0].a;
            in_b     = vq[0].b;
            in_tag   = vq[0].tag;
`ifdef YSYX_23060077_ADDER_SAT_EN
            in_sat   = vq[0].sat;
`endif
        end else begin
            in_valid = 1'b0;
        end
        #1;
        acc      = in_valid && in_ready;
        last_rdy = in_ready;
        iss      = cyc;
        @(posedge clock);
        if (acc) begin
            vec_t v;
            exp_t e;
            v = vq.pop_front();
            e.resp    = {v.res, v.c, v.v, v.z, v.tag};
            e.issue   = iss;
            e.chk_lat = lat_mode;
            sb.push_back(e);
            n_acc++;
        end
    endtask

    task automatic send_all(input bit ordy);
        int n = 0;
        while (vq.size() > 0 && n < 200) begin
            step(1'b1, ordy);
            n++;
        end
        if (vq.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: %0d unsent, expected 0", vq.size());
            vq.delete();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            step(1'b0, 1'b1);
            n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_flush(input int exp_drop);
        @(negedge clock);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        in_op = ADD; in_a = 32'h1; in_b = 32'h1; in_tag = 4'hE;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_dropped", 64'(sb.size()), 64'(exp_drop));
        sb.delete();
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = ADD; in_a = '0; in_b = '0; in_tag = '0;
`ifdef YSYX_23060077_ADDER_SAT_EN
        in_sat = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_flags", 64'({out_carry, out_ovf, out_zero}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_release_in_ready", 64'(in_ready), 64'd1);

        // Directed arithmetic and compares.
        lat_mode = 1'b1;
        addv(ADD,  32'hFFFF_FFFF, 32'h0000_0001, 4'h1, 0, 32'h0000_0000, 1, 0, 1);
        addv(SUB,  32'h8000_0000, 32'h0000_0001, 4'h2, 0, 32'h7FFF_FFFF, 1, 1, 0);
        addv(SLT,  32'h8000_0000, 32'h0000_0001, 4'h3, 0, 32'h0000_0001, 1, 1, 0);
        addv(SLTU, 32'h0000_0001, 32'h0000_0002, 4'h4, 0, 32'h0000_0001, 0, 0, 0);
        addv(SUB,  32'h0000_0005, 32'h0000_0005, 4'h5, 0, 32'h0000_0000, 1, 0, 1);
        addv(SLTU, 32'h0000_0002, 32'h0000_0001, 4'h6, 0, 32'h0000_0000, 1, 0, 1);
        addv(SLT,  32'h0000_0001, 32'h0000_0002, 4'h7, 0, 32'h0000_0001, 0, 0, 0);
        addv(SLT,  32'hFFFF_FFFF, 32'h0000_0001, 4'h8, 0, 32'h0000_0001, 1, 0, 0);
        send_all(1'b1);
        drain();

        // Eight back-to-back ops: latency 4 each implies consecutive in-order results.
        addv(ADD,  32'h0000_0001, 32'h0000_0002, 4'h8, 0, 32'h0000_0003, 0, 0, 0);
        addv(ADD,  32'h7FFF_FFFF, 32'h0000_0001, 4'h9, 0, 32'h8000_0000, 0, 1, 0);
        addv(ADD,  32'h0000_FFFF, 32'h0000_0001, 4'hA, 0, 32'h0001_0000, 0, 0, 0);
        addv(ADD,  32'h1234_5678, 32'h1111_1111, 4'hB, 0, 32'h2345_6789, 0, 0, 0);
        addv(SUB,  32'h0000_0000, 32'h0000_0001, 4'hC, 0, 32'hFFFF_FFFF, 0, 0, 0);
        addv(ADD,  32'h8000_0000, 32'h8000_0000, 4'hD, 0, 32'h0000_0000, 1, 1, 1);
        addv(SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'hE, 0, 32'h8000_0000, 0, 1, 0);
        addv(SLTU, 32'hFFFF_FFFF, 32'h0000_0000, 4'hF, 0, 32'h0000_0000, 1, 0, 1);
        send_all(1'b1);
        drain();

        // Stall: pipe takes four ops then stops accepting; held output must not move.
        lat_mode = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            addv(ADD, 32'(i * 16), 32'h1, 4'(i), 0, 32'(i * 16 + 1), 0, 0, 0);
        end
        n_acc = 0;
        repeat (8) step(1'b1, 1'b0);
        check("stall_accepted", 64'(n_acc), 64'd4);
        check("stall_in_ready", 64'(last_rdy), 64'd0);
        send_all(1'b1);
        drain();

        // Flush with three in flight, then with the oldest leaving in the flush cycle.
        lat_mode = 1'b1;
        addv(ADD, 32'h1, 32'h1, 4'h1, 0, 32'h2, 0, 0, 0);
        addv(ADD, 32'h2, 32'h1, 4'h2, 0, 32'h3, 0, 0, 0);
        addv(ADD, 32'h3, 32'h1, 4'h3, 0, 32'h4, 0, 0, 0);
        send_all(1'b1);
        do_flush(3);
        addv(ADD, 32'h4, 32'h1, 4'h4, 0, 32'h5, 0, 0, 0);
        addv(ADD, 32'h5, 32'h1, 4'h5, 0, 32'h6, 0, 0, 0);
        addv(ADD, 32'h6, 32'h1, 4'h6, 0, 32'h7, 0, 0, 0);
        addv(ADD, 32'h7, 32'h1, 4'h7, 0, 32'h8, 0, 0, 0);
        send_all(1'b1);
        do_flush(3);
        addv(ADD, 32'h0000_000A, 32'h0000_0005, 4'h9, 0, 32'h0000_000F, 0, 0, 0);
        send_all(1'b1);
        drain();

        // Reset with the pipe full.
        lat_mode = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            addv(ADD, 32'(i), 32'h1, 4'(i), 0, 32'(i + 1), 0, 0, 0);
        end
        send_all(1'b0);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        check("rst_full_out_valid", 64'(out_valid), 64'd0);
        check("rst_full_result", 64'(out_result), 64'd0);
        check("rst_full_tag", 64'(out_tag), 64'd0);
        check("rst_full_inflight", 64'(sb.size()), 64'd4);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_full_release_in_ready", 64'(in_ready), 64'd1);
        lat_mode = 1'b1;
        addv(ADD, 32'h0000_0100, 32'h0000_0200, 4'h3, 0, 32'h0000_0300, 0, 0, 0);
        send_all(1'b1);
        drain();

`ifdef YSYX_23060077_ADDER_SAT_EN
        addv(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'h1, 1, 32'h7FFF_FFFF, 0, 1, 0);
        addv(SUB, 32'h8000_0000, 32'h0000_0001, 4'h2, 1, 32'h8000_0000, 1, 1, 0);
        addv(SLT, 32'h8000_0000, 32'h0000_0001, 4'h3, 1, 32'h0000_0001, 1, 1, 0);
        addv(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'h4, 0, 32'h8000_0000, 0, 1, 0);
        send_all(1'b1);
        drain();
`endif

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
